// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle multiply/divide unit with HI/LO registers.
// The result is computed combinationally at the start edge and parked in
// pending_hi/pending_lo; busy then runs for the configured latency and the
// pending value is committed on the edge that ends the busy window.
// Optional feature macro: MDU_MADD_EN enables MADD (op 6) / MSUB (op 7)
// accumulate into {hi,lo}; without it ops 6/7 are no-ops.
module mdu_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   count;
    logic [WIDTH-1:0]   pending_hi;
    logic [WIDTH-1:0]   pending_lo;
    logic               pending_we;
    logic               launch;
    logic               finish;

    logic               is_mul;
    logic               is_div;
    logic               is_mac;
    logic               is_mthi;
    logic               is_mtlo;

    logic [2*WIDTH-1:0] a_sx;
    logic [2*WIDTH-1:0] b_sx;
    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] prod_u;

    logic               div_signed;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   divisor;
    logic [WIDTH-1:0]   q_mag;
    logic [WIDTH-1:0]   r_mag;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;

    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;
    logic               res_we;
    logic [CNT_W-1:0]   res_cycles;

    // Opcode decode
    always_comb begin
        is_mul  = (op == 3'd0) || (op == 3'd1);
        is_div  = (op == 3'd2) || (op == 3'd3);
        is_mthi = (op == 3'd4);
        is_mtlo = (op == 3'd5);
`ifdef MDU_MADD_EN
        is_mac  = (op == 3'd6) || (op == 3'd7);
`else
        is_mac  = 1'b0;
`endif
    end

    // Signed and unsigned full-width products
    always_comb begin
        a_sx   = {{WIDTH{a[WIDTH-1]}}, a};
        b_sx   = {{WIDTH{b[WIDTH-1]}}, b};
        prod_s = a_sx * b_sx;
        prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    end

    // Sign-magnitude division; the magnitude path makes -2^(W-1) / -1 wrap
    // naturally to -2^(W-1) with a zero remainder
    always_comb begin
        div_signed = (op == 3'd2);
        a_neg      = div_signed & a[WIDTH-1];
        b_neg      = div_signed & b[WIDTH-1];
        a_mag      = a_neg ? (WIDTH'(0) - a) : a;
        b_mag      = b_neg ? (WIDTH'(0) - b) : b;
        divisor    = (b == '0) ? WIDTH'(1) : b_mag;
        q_mag      = a_mag / divisor;
        r_mag      = a_mag % divisor;
        quot       = (a_neg ^ b_neg) ? (WIDTH'(0) - q_mag) : q_mag;
        rem        = a_neg ? (WIDTH'(0) - r_mag) : r_mag;
    end

    // Result selection for the operation being launched
    always_comb begin
        res_hi     = hi;
        res_lo     = lo;
        res_we     = 1'b0;
        res_cycles = CNT_W'(MULT_CYCLES);
        case (op)
            3'd0: begin
                {res_hi, res_lo} = prod_s;
                res_we           = 1'b1;
            end
            3'd1: begin
                {res_hi, res_lo} = prod_u;
                res_we           = 1'b1;
            end
            3'd2, 3'd3: begin
                res_hi     = rem;
                res_lo     = quot;
                res_we     = (b != '0);
                res_cycles = CNT_W'(DIV_CYCLES);
            end
`ifdef MDU_MADD_EN
            3'd6: begin
                {res_hi, res_lo} = {hi, lo} + prod_s;
                res_we           = 1'b1;
            end
            3'd7: begin
                {res_hi, res_lo} = {hi, lo} - prod_s;
                res_we           = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Next-state logic and busy output
    always_comb begin
        state_next = state;
        launch     = 1'b0;
        finish     = 1'b0;
        busy       = (state == S_RUN);
        case (state)
            S_IDLE: begin
                if (start && (is_mul || is_div || is_mac)) begin
                    launch     = 1'b1;
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (count == CNT_W'(1)) begin
                    finish     = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Latency counter, pending result and HI/LO registers
    always_ff @(posedge clk) begin
        if (reset) begin
            hi         <= '0;
            lo         <= '0;
            count      <= '0;
            pending_hi <= '0;
            pending_lo <= '0;
            pending_we <= 1'b0;
        end else begin
            if (launch) begin
                pending_hi <= res_hi;
                pending_lo <= res_lo;
                pending_we <= res_we;
                count      <= res_cycles;
            end else if (state == S_RUN) begin
                count <= count - CNT_W'(1);
            end
            if (finish) begin
                pending_we <= 1'b0;
                if (pending_we) begin
                    hi <= pending_hi;
                    lo <= pending_lo;
                end
            end
            if ((state == S_IDLE) && start && is_mthi) hi <= a;
            if ((state == S_IDLE) && start && is_mtlo) lo <= a;
        end
    end

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: directed cases plus randomized ops
// checked against an arithmetic reference model of HI/LO.
module tb_mdu_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    mdu_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: updates m_hi/m_lo and returns the expected busy length
    task automatic model_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                            output int len);
        longint      sx = longint'($signed(x));
        longint      sy = longint'($signed(y));
        longint      q;
        longint      r;
        logic [63:0] p;
        len = 0;
        case (o)
            3'd0: begin p = 64'(sx * sy); {m_hi, m_lo} = p; len = 5; end
            3'd1: begin p = {32'd0, x} * {32'd0, y}; {m_hi, m_lo} = p; len = 5; end
            3'd2: begin
                len = 10;
                if (y != 0) begin
                    q = sx / sy; r = sx % sy;
                    m_lo = q[31:0]; m_hi = r[31:0];
                end
            end
            3'd3: begin
                len = 10;
                if (y != 0) begin m_lo = x / y; m_hi = x % y; end
            end
            3'd4: m_hi = x;
            3'd5: m_lo = x;
            default: begin
`ifdef MDU_MADD_EN
                p = 64'(sx * sy);
                if (o == 3'd6) {m_hi, m_lo} = {m_hi, m_lo} + p;
                else           {m_hi, m_lo} = {m_hi, m_lo} - p;
                len = 5;
`endif
            end
        endcase
    endtask

    // Issue one op, optionally fire a stray start in busy cycle 2, then
    // verify busy length, hold of hi/lo while busy and the final values
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input bit inject);
        int          len;
        int          cnt;
        bit          done;
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        old_hi = m_hi;
        old_lo = m_lo;
        model_op(o, x, y, len);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
        cnt  = 0;
        done = 1'b0;
        if (len == 0) begin
            @(negedge clk);
            check("nobusy", busy, 1'b0);
        end else begin
            for (int i = 0; i < 40 && !done; i++) begin
                @(negedge clk);
                start = 1'b0;
                if (!busy) done = 1'b1;
                else begin
                    cnt++;
                    check("hold_hi", hi, old_hi);
                    check("hold_lo", lo, old_lo);
                    if (inject && cnt == 2) begin
                        start = 1'b1; op = 3'($urandom); a = $urandom; b = $urandom;
                    end
                end
            end
            check("busy_len", cnt, len);
        end
        check("hi", hi, m_hi);
        check("lo", lo, m_lo);
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] rx;
        logic [31:0] ry;
        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);

        run_op(3'd0, 32'hFFFFFFFF, 32'h3, 1'b0);
        check("mult_hi", hi, 32'hFFFFFFFF);
        check("mult_lo", lo, 32'hFFFFFFFD);
        run_op(3'd1, 32'hFFFFFFFF, 32'h2, 1'b1);
        check("multu_hi", hi, 32'h00000001);
        check("multu_lo", lo, 32'hFFFFFFFE);
        run_op(3'd2, 32'hFFFFFFF9, 32'h2, 1'b0);
        check("div_lo", lo, 32'hFFFFFFFD);
        check("div_hi", hi, 32'hFFFFFFFF);
        run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b1);
        check("divovf_lo", lo, 32'h80000000);
        check("divovf_hi", hi, 32'h0);
        run_op(3'd4, 32'h12345678, 32'h0, 1'b0);
        check("mthi", hi, 32'h12345678);
        run_op(3'd5, 32'h9ABCDEF0, 32'h0, 1'b0);
        check("mtlo", lo, 32'h9ABCDEF0);
        run_op(3'd3, 32'h55555555, 32'h0, 1'b0);
        check("div0_hi", hi, 32'h12345678);
        check("div0_lo", lo, 32'h9ABCDEF0);

        // Reset during cycle 3 of a DIV discards the in-flight result
        @(negedge clk);
        op = 3'd2; a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        m_hi = '0; m_lo = '0;
        @(negedge clk);
        check("rstrun_busy", busy, 1'b0);
        check("rstrun_hi", hi, 32'h0);
        check("rstrun_lo", lo, 32'h0);
        repeat (15) @(negedge clk);
        check("rstrun_late_hi", hi, 32'h0);
        check("rstrun_late_lo", lo, 32'h0);
        check("rstrun_late_busy", busy, 1'b0);

        run_op(3'd4, 32'h0, 32'h0, 1'b0);
        run_op(3'd5, 32'hFFFFFFFF, 32'h0, 1'b0);
        run_op(3'd6, 32'h1, 32'h1, 1'b0);
`ifdef MDU_MADD_EN
        check("madd_hi", hi, 32'h00000001);
        check("madd_lo", lo, 32'h00000000);
`else
        check("madd_hi", hi, 32'h0);
        check("madd_lo", lo, 32'hFFFFFFFF);
`endif
        run_op(3'd7, 32'h2, 32'h1, 1'b0);
`ifdef MDU_MADD_EN
        check("msub_hi", hi, 32'h0);
        check("msub_lo", lo, 32'hFFFFFFFE);
`else
        check("msub_hi", hi, 32'h0);
        check("msub_lo", lo, 32'hFFFFFFFF);
`endif

        for (int i = 0; i < 60; i++) begin
            ro = 3'($urandom_range(0, 7));
            rx = $urandom;
            ry = $urandom;
            case ($urandom_range(0, 7))
                0: ry = 32'h0;
                1: ry = 32'($urandom_range(1, 9));
                2: begin rx = 32'h80000000; ry = 32'hFFFFFFFF; end
                3: rx = 32'hFFFFFFFF;
                default: ;
            endcase
            run_op(ro, rx, ry, $urandom_range(0, 3) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
